// File: rtl/div_three_tx_if.sv
// Parallel-in handshake and framed serial-out bundle for the div-by-3 transmitter.
// master is the word producer / serial consumer side, slave is the transmitter.
interface div_three_tx_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_word;
  logic [LEN_W-1:0] in_len;
  logic             out_data;
  logic             out_data_start;
  logic             out_data_finish;
  logic             out_busy;
  logic             out_done;
  logic [1:0]       out_rem;
  logic             out_is_div_three;

  modport master (
    output in_valid, in_word, in_len,
    input  in_ready, out_data, out_data_start, out_data_finish,
    input  out_busy, out_done, out_rem, out_is_div_three
  );

  modport slave (
    input  in_valid, in_word, in_len,
    output in_ready, out_data, out_data_start, out_data_finish,
    output out_busy, out_done, out_rem, out_is_div_three
  );
endinterface

// File: rtl/div_three_tx.sv
// Serial MSB-first transmitter with start/finish framing and a running mod-3
// reference of the bits sent, reported on the cycle after the last bit.
module div_three_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  div_three_tx_if.slave bus
);

  localparam logic [0:0]       IDLE    = 1'b0;
  localparam logic [0:0]       SEND    = 1'b1;
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  // Appending bit b to a value with remainder r gives remainder (2r + b) mod 3.
  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    logic [1:0] nxt;
    case ({r, b})
      3'b000:  nxt = 2'd0;
      3'b001:  nxt = 2'd1;
      3'b010:  nxt = 2'd2;
      3'b011:  nxt = 2'd0;
      3'b100:  nxt = 2'd1;
      3'b101:  nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       acc_q, acc_d;
  logic             data_q, data_d;
  logic             start_q, start_d;
  logic             finish_q, finish_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       rem_q, rem_d;
  logic             div3_q, div3_d;

  logic [LEN_W-1:0] len_eff;
  logic [WIDTH-1:0] aligned;

  // Out-of-range lengths (0 or above WIDTH) fall back to a full word.
  always_comb begin
    len_eff = WIDTH_L;
    if ((bus.in_len != '0) && (bus.in_len <= WIDTH_L)) begin
      len_eff = bus.in_len;
    end
  end

  // Left-justify the word so bit L-1 sits at the MSB and unused bits shift out.
  assign aligned = bus.in_word << (WIDTH_L - len_eff);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    data_d   = 1'b0;
    start_d  = 1'b0;
    finish_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    rem_d    = rem_q;
    div3_d   = div3_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d  = SEND;
          data_d   = aligned[WIDTH-1];
          shift_d  = aligned << 1;
          cnt_d    = len_eff - ONE_L;
          acc_d    = mod3_step(2'd0, aligned[WIDTH-1]);
          start_d  = 1'b1;
          finish_d = (len_eff == ONE_L);
          busy_d   = 1'b1;
          rem_d    = 2'd0;
          div3_d   = 1'b1;
        end
      end
      default: begin
        // cnt_q counts bits still to present after the one currently on out_data.
        if (cnt_q != '0) begin
          data_d   = shift_q[WIDTH-1];
          shift_d  = shift_q << 1;
          cnt_d    = cnt_q - ONE_L;
          acc_d    = mod3_step(acc_q, shift_q[WIDTH-1]);
          finish_d = (cnt_q == ONE_L);
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          rem_d   = acc_q;
          div3_d  = (acc_q == 2'd0);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      acc_q    <= 2'd0;
      data_q   <= 1'b0;
      start_q  <= 1'b0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rem_q    <= 2'd0;
      div3_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      start_q  <= start_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rem_q    <= rem_d;
      div3_q   <= div3_d;
    end
  end

  assign bus.in_ready         = (state_q == IDLE);
  assign bus.out_data         = data_q;
  assign bus.out_data_start   = start_q;
  assign bus.out_data_finish  = finish_q;
  assign bus.out_busy         = busy_q;
  assign bus.out_done         = done_q;
  assign bus.out_rem          = rem_q;
  assign bus.out_is_div_three = div3_q;

endmodule
